// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Purpose:
//   Chooses the 16-bit value that the 4-digit seven-segment multiplexer shows.
//   By default it shows the live value, which holds the mouse X/Y bytes.
//   A second requester can post a one-shot message. The message replaces the
//   live value for HOLD_CYCLES clocks, and then the display goes back to live.
//
// Optional build macro:
//   SEG_SCHED_MSG_QUEUE_EN
//     Adds a one-entry pending buffer.
//     A request accepted during a hold is stored and shown after the current
//     hold ends; it does not restart the current hold.
//     With the macro undefined, a request accepted during a hold replaces the
//     message and restarts the hold (retrigger).
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_live_data    live value, [15:12] = leftmost digit
//   i_live_valid   qualifier for i_live_data
//   i_freeze       1 = ignore i_live_valid and keep the last live value
//   i_msg_data     message value, valid while i_msg_req = 1
//   i_msg_req      message request (level)
//   o_msg_ack      one-cycle pulse when a message is accepted
//   o_digit1..4    displayed nibbles, o_digit1 leftmost (AN3)
//   o_showing_msg  1 while the message is on the display
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_live_data,
  input  logic        i_live_valid,
  input  logic        i_freeze,
  input  logic [15:0] i_msg_data,
  input  logic        i_msg_req,
  output logic        o_msg_ack,
  output logic [3:0]  o_digit1,
  output logic [3:0]  o_digit2,
  output logic [3:0]  o_digit3,
  output logic [3:0]  o_digit4,
  output logic        o_showing_msg
);

  typedef enum logic {ST_LIVE = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [15:0]       r_live;
  logic [15:0]       r_msg;
  logic [15:0]       w_msg_next;
  logic              r_msg_ack;
  logic [15:0]       r_shown;
  logic              r_showing;
  logic [15:0]       w_shown_next;
  logic              w_showing_next;
  logic              w_accept;
  logic              w_expire;

`ifdef SEG_SCHED_MSG_QUEUE_EN
  logic              r_pend_valid;
  logic              w_pend_valid_next;
  logic [15:0]       r_pend_data;
  logic [15:0]       w_pend_data_next;

  // A full pending slot blocks new requests while a hold is in progress.
  // The requester keeps MSG_REQ high until the slot is free.
  assign w_accept = i_msg_req && !r_msg_ack && !((r_state == ST_HOLD) && r_pend_valid);
`else
  // The registered ACK masks the request for one cycle. Without this, the
  // request still high in the ACK cycle would be accepted a second time.
  assign w_accept = i_msg_req && !r_msg_ack;
`endif

  assign w_expire = (r_state == ST_HOLD) && (r_cnt == LP_LAST);

  // State register and all storage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_LIVE;
      r_cnt        <= '0;
      r_live       <= '0;
      r_msg        <= '0;
      r_msg_ack    <= 1'b0;
      r_shown      <= '0;
      r_showing    <= 1'b0;
`ifdef SEG_SCHED_MSG_QUEUE_EN
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_msg        <= w_msg_next;
      r_msg_ack    <= w_accept;
      r_shown      <= w_shown_next;
      r_showing    <= w_showing_next;
      // Live capture runs in both states, so the display returns to an
      // up-to-date live value when a hold ends.
      if (i_live_valid && !i_freeze) begin
        r_live <= i_live_data;
      end
`ifdef SEG_SCHED_MSG_QUEUE_EN
      r_pend_valid <= w_pend_valid_next;
      r_pend_data  <= w_pend_data_next;
`endif
    end
  end

  // Next-state and hold-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_msg_next   = r_msg;
`ifdef SEG_SCHED_MSG_QUEUE_EN
    w_pend_valid_next = r_pend_valid;
    w_pend_data_next  = r_pend_data;
`endif
    case (r_state)
      ST_LIVE: begin
        if (w_accept) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
          w_msg_next   = i_msg_data;
        end
      end
      ST_HOLD: begin
`ifdef SEG_SCHED_MSG_QUEUE_EN
        if (w_expire) begin
          w_cnt_next = '0;
          if (r_pend_valid) begin
            w_msg_next        = r_pend_data;
            w_pend_valid_next = 1'b0;
          end else if (w_accept) begin
            // The slot is empty and the hold ends now, so show the request
            // directly. Staging it would leave a one-cycle live gap.
            w_msg_next = i_msg_data;
          end else begin
            w_state_next = ST_LIVE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
          if (w_accept) begin
            w_pend_valid_next = 1'b1;
            w_pend_data_next  = i_msg_data;
          end
        end
`else
        // Acceptance has priority over expiry. This lets back-to-back
        // messages continue without a live gap.
        if (w_accept) begin
          w_cnt_next = '0;
          w_msg_next = i_msg_data;
        end else if (w_expire) begin
          w_cnt_next   = '0;
          w_state_next = ST_LIVE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
`endif
      end
      default: begin
        w_state_next = ST_LIVE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output selection. The source comes from the registered state, so the
  // digits follow a capture or an acceptance by exactly one clock.
  always_comb begin
    w_showing_next = (r_state == ST_HOLD);
    w_shown_next   = (r_state == ST_HOLD) ? r_msg : r_live;
  end

  assign o_msg_ack     = r_msg_ack;
  assign o_showing_msg = r_showing;
  assign o_digit1      = r_shown[15:12];
  assign o_digit2      = r_shown[11:8];
  assign o_digit3      = r_shown[7:4];
  assign o_digit4      = r_shown[3:0];

endmodule

// File: tb/tb_seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scheduler
//
// Self-checking bench with directed steps followed by a random phase.
// The reference model keeps the displayed message and the number of display
// cycles it still has left.
// -----------------------------------------------------------------------------
module tb_seg_display_scheduler;

  localparam int HOLD  = 8;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] live_data;
  logic        live_valid;
  logic        freeze;
  logic [15:0] msg_data;
  logic        msg_req;
  logic        msg_ack;
  logic [3:0]  d1, d2, d3, d4;
  logic        showing;

  always #5 clk = ~clk;

  seg_display_scheduler #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_live_data  (live_data),
    .i_live_valid (live_valid),
    .i_freeze     (freeze),
    .i_msg_data   (msg_data),
    .i_msg_req    (msg_req),
    .o_msg_ack    (msg_ack),
    .o_digit1     (d1),
    .o_digit2     (d2),
    .o_digit3     (d3),
    .o_digit4     (d4),
    .o_showing_msg(showing)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [15:0] m_live, m_msg;
  int          m_left;       // message display cycles still owed, 0 = live
  logic        m_ack;
  logic [15:0] exp_shown;
  logic        exp_showing;
  logic        exp_ack;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_live = '0; m_msg = '0; m_left = 0; m_ack = 1'b0;
    exp_shown = '0; exp_showing = 1'b0; exp_ack = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare the DUT outputs 1 time unit after the edge.
  task automatic step(input string tag);
    logic acc;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      exp_showing = (m_left > 0);
      exp_shown   = exp_showing ? m_msg : m_live;
      acc = msg_req && !m_ack;
      if (acc) begin
        m_msg  = msg_data;
        m_left = HOLD;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (live_valid && !freeze) m_live = live_data;
      m_ack   = acc;
      exp_ack = acc;
    end
    #1;
    check({tag, "_digits"},  {d1, d2, d3, d4}, exp_shown);
    check({tag, "_showing"}, 16'(showing),     16'(exp_showing));
    check({tag, "_ack"},     16'(msg_ack),     16'(exp_ack));
    $display("step %-8s t=%0t digits=%h show=%b ack=%b", tag, $time, {d1, d2, d3, d4}, showing, msg_ack);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic live_pulse(input logic [15:0] v, input string tag);
    live_data  = v;
    live_valid = 1'b1;
    step(tag);
    live_valid = 1'b0;
  endtask

  // Hold the request until the DUT acknowledges it, bounded to 4 clocks.
  task automatic send_msg(input logic [15:0] v, input string tag);
    msg_data = v;
    msg_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(tag);
      if (msg_ack) break;
    end
    check({tag, "_ack_seen"}, 16'(msg_ack), 16'd1);
    msg_req = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    check({tag, "_async_digits"}, {d1, d2, d3, d4}, 16'h0000);
    check({tag, "_async_show"},   16'(showing),     16'd0);
    check({tag, "_async_ack"},    16'(msg_ack),     16'd0);
  endtask

  int win;

  initial begin
    rst = 1'b1; live_data = '0; live_valid = 1'b0; freeze = 1'b0;
    msg_data = '0; msg_req = 1'b0;
    model_clear();
    #1;
    check("por_digits", {d1, d2, d3, d4}, 16'h0000);
    check("por_show",   16'(showing),     16'd0);
    check("por_ack",    16'(msg_ack),     16'd0);
    idle(2, "rst");
    #3 rst = 1'b0;

    // Live path latency: the value appears two clocks after the pulse.
    live_pulse(16'h12AB, "live");
    step("live");
    check("live_12AB", {d1, d2, d3, d4}, 16'h12AB);

    // Message display window.
    send_msg(16'hE005, "msg");
    win = 0;
    for (int i = 0; i < 10; i++) begin
      step("hold");
      if (showing) win++;
    end
    check("hold_len", 16'(win), 16'(HOLD));
    check("after_hold", {d1, d2, d3, d4}, 16'h12AB);

    // Freeze.
    freeze = 1'b1;
    live_pulse(16'h3333, "frz");
    live_pulse(16'h3333, "frz");
    idle(2, "frz");
    freeze = 1'b0;
    check("freeze_keep", {d1, d2, d3, d4}, 16'h12AB);

    // Live update during a hold appears after the hold.
    send_msg(16'h0A0A, "msg2");
    idle(2, "msg2");
    live_pulse(16'h4444, "msg2");
    idle(10, "msg2");
    check("live_after_msg", {d1, d2, d3, d4}, 16'h4444);

    // Retrigger mid-hold.
    send_msg(16'h1111, "rtg");
    idle(3, "rtg");
    send_msg(16'hBEEF, "rtg");
    win = 0;
    for (int i = 0; i < 12; i++) begin
      step("rtg");
      if ({d1, d2, d3, d4} == 16'hBEEF) win++;
    end
    check("beef_len", 16'(win), 16'(HOLD));

    // Request sampled on the expiry cycle: no live gap.
    send_msg(16'h2222, "exp");
    idle(7, "exp");
    send_msg(16'h3434, "exp");
    win = 0;
    for (int i = 0; i < 12; i++) begin
      step("exp");
      if (showing) win++;
    end
    check("expiry_chain", 16'(win), 16'(HOLD));

    // Asynchronous reset mid-hold, with a request held across the release.
    send_msg(16'h5A5A, "arst");
    idle(3, "arst");
    msg_data = 16'h6789;
    msg_req  = 1'b1;
    async_reset("arst");
    idle(2, "arst");
    #3 rst = 1'b0;
    step("arst");
    check("arst_reaccept", 16'(msg_ack), 16'd1);
    msg_req = 1'b0;
    idle(10, "arst");

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      live_valid = ($urandom_range(0, 2) == 0);
      live_data  = 16'($urandom);
      freeze     = ($urandom_range(0, 4) == 0);
      msg_req    = ($urandom_range(0, 9) == 0);
      msg_data   = 16'($urandom);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
